// File: rtl/serial_byte_loader_if.sv
// ---------------------------------------------------------------------------
// serial_byte_loader_if
//   Bundles the frame-side handshake and result signals of the serial byte
//   loader so that the feeder and the loader connect through one port.
//
//   Signals
//     start       frame start request (master -> slave)
//     sin         serial data bit (master -> slave)
//     sin_valid   sin carries a valid bit this cycle (master -> slave)
//     busy        frame in progress (slave -> master)
//     data_out    last good word, WIDTH bits (slave -> master)
//     load        one-cycle strobe, data_out holds a new good word
//     parity_err  one-cycle strobe, frame dropped on parity mismatch
// ---------------------------------------------------------------------------
interface serial_byte_loader_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sin;
    logic             sin_valid;
    logic             busy;
    logic [WIDTH-1:0] data_out;
    logic             load;
    logic             parity_err;

    modport master (
        output start,
        output sin,
        output sin_valid,
        input  busy,
        input  data_out,
        input  load,
        input  parity_err
    );

    modport slave (
        input  start,
        input  sin,
        input  sin_valid,
        output busy,
        output data_out,
        output load,
        output parity_err
    );
endinterface

// File: rtl/serial_byte_loader.sv
// ---------------------------------------------------------------------------
// serial_byte_loader
//   Assembles a serial bit stream into a WIDTH-bit word, optionally checks a
//   trailing even-parity bit, and presents good words on data_out with a
//   single-cycle load strobe for a downstream enable-gated holding register.
//   Frames with a parity mismatch are dropped and flagged with parity_err.
//
//   Ports
//     clk   system clock, all state updates on posedge
//     rst_  asynchronous active-low reset
//     bus   serial_byte_loader_if.slave: start, sin, sin_valid in;
//           busy, data_out, load, parity_err out (all outputs registered)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; sin/sin_valid ignored
//   SHIFT  | accepting WIDTH data bits on sin_valid cycles
//   PARITY | waiting for the parity bit (PARITY_EN=1 only)
//   DONE   | one cycle: data_out updated, load high
// ---------------------------------------------------------------------------
module serial_byte_loader #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                  clk,
    input logic                  rst_,
    serial_byte_loader_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("serial_byte_loader: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] data_r;
    logic             load_r;
    logic             perr_r;
    logic             busy_r;
    logic [WIDTH-1:0] shift_next;

    // Word after accepting the current sin bit; the first bit received ends
    // up in the MSB or LSB once all WIDTH bits have been shifted in.
    always_comb begin
        shift_next = shreg;
        if (MSB_FIRST) begin
            shift_next = {shreg[WIDTH-2:0], bus.sin};
        end else begin
            shift_next = {bus.sin, shreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            data_r <= '0;
            load_r <= 1'b0;
            perr_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            // Strobes are single-cycle by default.
            load_r <= 1'b0;
            perr_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SHIFT;
                        shreg  <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    // start is deliberately not looked at here: a frame in
                    // progress cannot be restarted.
                    if (bus.sin_valid) begin
                        shreg <= shift_next;
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST_IDX) begin
                            if (PARITY_EN) begin
                                state <= PARITY;
                            end else begin
                                state  <= DONE;
                                data_r <= shift_next;
                                load_r <= 1'b1;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (bus.sin_valid) begin
                        // Even parity overall: parity bit equals XOR of data.
                        if (bus.sin == ^shreg) begin
                            state  <= DONE;
                            data_r <= shreg;
                            load_r <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            perr_r <= 1'b1;
                            busy_r <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.data_out   = data_r;
    assign bus.load       = load_r;
    assign bus.parity_err = perr_r;

endmodule

// File: tb/tb_serial_byte_loader.sv
module tb_serial_byte_loader;

    logic clk;
    logic rst_;

    int n_vec;
    int n_miss;

    serial_byte_loader_if #(.WIDTH(8)) bus_p ();
    serial_byte_loader_if #(.WIDTH(8)) bus_np ();

    serial_byte_loader #(
        .WIDTH(8), .PARITY_EN(1'b1), .MSB_FIRST(1'b1)
    ) u_dut_p (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus_p)
    );

    serial_byte_loader #(
        .WIDTH(8), .PARITY_EN(1'b0), .MSB_FIRST(1'b0)
    ) u_dut_np (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus_np)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs/outputs settle 1 time unit after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_p();
        bus_p.start = 1'b1;
        tick();
        bus_p.start = 1'b0;
    endtask

    task automatic bit_p(input logic b);
        bus_p.sin       = b;
        bus_p.sin_valid = 1'b1;
        tick();
        bus_p.sin_valid = 1'b0;
        bus_p.sin       = 1'b0;
    endtask

    task automatic byte_p(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            bit_p(w[i]);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        bus_p.start = 0; bus_p.sin = 0; bus_p.sin_valid = 0;
        bus_np.start = 0; bus_np.sin = 0; bus_np.sin_valid = 0;
        rst_ = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", bus_p.data_out, 8'h00);
        chk("rst_load", bus_p.load, 1'b0);
        chk("rst_busy", bus_p.busy, 1'b0);
        chk("rst_perr", bus_p.parity_err, 1'b0);
        rst_ = 1'b1;
        tick();

        // 1: A5, parity 0
        start_p();
        chk("t1_busy", bus_p.busy, 1'b1);
        byte_p(8'hA5);
        chk("t1_noload_pre_par", bus_p.load, 1'b0);
        bit_p(1'b0);
        chk("t1_load", bus_p.load, 1'b1);
        chk("t1_data", bus_p.data_out, 8'hA5);
        chk("t1_perr", bus_p.parity_err, 1'b0);
        chk("t1_busy_done", bus_p.busy, 1'b1);
        tick();
        chk("t1_load_off", bus_p.load, 1'b0);
        chk("t1_busy_off", bus_p.busy, 1'b0);

        // 2: 3C, bad parity 1
        start_p();
        byte_p(8'h3C);
        bit_p(1'b1);
        chk("t2_perr", bus_p.parity_err, 1'b1);
        chk("t2_load", bus_p.load, 1'b0);
        chk("t2_data", bus_p.data_out, 8'hA5);
        chk("t2_busy", bus_p.busy, 1'b0);
        tick();
        chk("t2_perr_off", bus_p.parity_err, 1'b0);

        // 3: FF with a 3-cycle gap between bits 4 and 5
        start_p();
        for (int i = 0; i < 4; i++) bit_p(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_gap_busy", bus_p.busy, 1'b1);
        end
        for (int i = 0; i < 4; i++) bit_p(1'b1);
        chk("t3_noload_pre_par", bus_p.load, 1'b0);
        bit_p(1'b0);
        chk("t3_load", bus_p.load, 1'b1);
        chk("t3_perr", bus_p.parity_err, 1'b0);
        chk("t3_data", bus_p.data_out, 8'hFF);
        tick();

        // 4: abort with async reset mid-frame, then 81
        start_p();
        bit_p(1'b1); bit_p(1'b1); bit_p(1'b1);
        #3 rst_ = 1'b0;
        #1;
        chk("t4_rst_data", bus_p.data_out, 8'h00);
        chk("t4_rst_busy", bus_p.busy, 1'b0);
        chk("t4_rst_load", bus_p.load, 1'b0);
        tick();
        rst_ = 1'b1;
        tick();
        start_p();
        byte_p(8'h81);
        bit_p(1'b0);
        chk("t4_load", bus_p.load, 1'b1);
        chk("t4_data", bus_p.data_out, 8'h81);
        tick();

        // 5: extra start after the 2nd bit of 5A is ignored
        start_p();
        bit_p(1'b0); bit_p(1'b1);
        bus_p.start = 1'b1;
        tick();
        bus_p.start = 1'b0;
        chk("t5_busy", bus_p.busy, 1'b1);
        bit_p(1'b0); bit_p(1'b1); bit_p(1'b1);
        bit_p(1'b0); bit_p(1'b1); bit_p(1'b0);
        bit_p(1'b0);
        chk("t5_load", bus_p.load, 1'b1);
        chk("t5_data", bus_p.data_out, 8'h5A);
        tick();

        // 6: no parity, LSB first: 1,1,0,0,0,0,0,0 -> 03
        bus_np.start = 1'b1;
        tick();
        bus_np.start = 1'b0;
        chk("t6_busy", bus_np.busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            bus_np.sin       = (i < 2);
            bus_np.sin_valid = 1'b1;
            tick();
            if (i < 7) chk("t6_noload_early", bus_np.load, 1'b0);
        end
        bus_np.sin_valid = 1'b0;
        bus_np.sin       = 1'b0;
        chk("t6_load", bus_np.load, 1'b1);
        chk("t6_data", bus_np.data_out, 8'h03);
        chk("t6_perr", bus_np.parity_err, 1'b0);
        tick();
        chk("t6_load_off", bus_np.load, 1'b0);
        chk("t6_busy_off", bus_np.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
